// File: rtl/irq_ctrl.sv
// irq_ctrl: N_IRQ-channel interrupt controller for the RV32IM core.
// Synchronises raw interrupt lines, keeps edge/level pending state,
// arbitrates by fixed priority (lowest index wins) and runs a single
// outstanding request/ack/done handshake toward the decode stage.
// A four-register config port (ENABLE, MODE, PENDING, STATUS) is
// reachable through the MMU.
module irq_ctrl #(
    parameter  int N_IRQ = 8,
    parameter  int W     = 32,
    localparam int IDW   = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             a_reset_n,
    input  logic [N_IRQ-1:0] irq_ext,
    input  logic             irq_gie,
    output logic             irq_req,
    output logic [IDW-1:0]   irq_id,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic             irq_active,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [W-1:0]     cfg_wdata,
    output logic [W-1:0]     cfg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_MODE    = 2'd1;
    localparam logic [1:0] A_PENDING = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    // Lowest-index set bit of a request vector; zero when the vector is empty.
    function automatic logic [IDW-1:0] lowest_index(input logic [N_IRQ-1:0] vec);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            idx = vec[i] ? IDW'(i) : idx;
        end
        return idx;
    endfunction

    // One-hot decode of a channel id.
    function automatic logic [N_IRQ-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [N_IRQ-1:0] vec;
        for (int i = 0; i < N_IRQ; i++) begin
            vec[i] = (IDW'(i) == id);
        end
        return vec;
    endfunction

    logic [N_IRQ-1:0] sync0_r, sync1_r, hist_r;
    logic [N_IRQ-1:0] pend_edge_r, enable_r, mode_r;
    logic [N_IRQ-1:0] edge_evt_s, pending_s, eligible_s;
    logic [N_IRQ-1:0] w1c_clr_s, ack_clr_s;
    logic [IDW-1:0]   winner_s, irq_id_r;
    logic             irq_req_r, irq_active_r;
    logic             take_s, ack_take_s;
    logic [W-1:0]     rdata_s;
    state_t           state_r, state_nxt_s;

    // Upper write-data bits have no register behind them.
    generate
        if (W > N_IRQ) begin : g_unused_wdata
            logic unused_wdata_s;
            assign unused_wdata_s = ^cfg_wdata[W-1:N_IRQ];
        end
    endgenerate

    assign edge_evt_s = sync1_r & ~hist_r & mode_r;
    assign pending_s  = (mode_r & pend_edge_r) | (~mode_r & sync1_r);
    assign eligible_s = pending_s & enable_r;
    assign winner_s   = lowest_index(eligible_s);
    assign w1c_clr_s  = (cfg_we && (cfg_addr == A_PENDING)) ?
                        (cfg_wdata[N_IRQ-1:0] & mode_r) : {N_IRQ{1'b0}};
    assign ack_clr_s  = ack_take_s ? id_onehot(irq_id_r) : {N_IRQ{1'b0}};

    // Two-flop synchroniser plus history flop per channel for edge detection.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            sync0_r <= '0;
            sync1_r <= '0;
            hist_r  <= '0;
        end else begin
            sync0_r <= irq_ext;
            sync1_r <= sync0_r;
            hist_r  <= sync1_r;
        end
    end

    // Edge pending bits: a new edge beats a same-cycle W1C or ack clear.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            pend_edge_r <= '0;
        end else begin
            pend_edge_r <= (pend_edge_r & ~(w1c_clr_s | ack_clr_s)) | edge_evt_s;
        end
    end

    // ENABLE and MODE configuration registers.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            enable_r <= '0;
            mode_r   <= '1;
        end else if (cfg_we && (cfg_addr == A_ENABLE)) begin
            enable_r <= cfg_wdata[N_IRQ-1:0];
        end else if (cfg_we && (cfg_addr == A_MODE)) begin
            mode_r   <= cfg_wdata[N_IRQ-1:0];
        end
    end

    // Handshake FSM state register.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE only, ack beats withdrawal in REQ.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        ack_take_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (irq_gie && (|eligible_s)) begin
                    state_nxt_s = ST_REQ;
                    take_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt_s = ST_SERVICE;
                    ack_take_s  = 1'b1;
                end else if (!irq_gie || !eligible_s[irq_id_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered handshake outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            irq_req_r    <= 1'b0;
            irq_active_r <= 1'b0;
            irq_id_r     <= '0;
        end else begin
            irq_req_r    <= (state_nxt_s == ST_REQ);
            irq_active_r <= (state_nxt_s == ST_SERVICE);
            if (take_s) begin
                irq_id_r <= winner_s;
            end
        end
    end

    // Config read mux; unimplemented upper bits read as zero.
    always_comb begin
        rdata_s = '0;
        case (cfg_addr)
            A_ENABLE:  rdata_s[N_IRQ-1:0] = enable_r;
            A_MODE:    rdata_s[N_IRQ-1:0] = mode_r;
            A_PENDING: rdata_s[N_IRQ-1:0] = pending_s;
            A_STATUS: begin
                rdata_s[IDW-1:0] = irq_id_r;
                rdata_s[IDW]     = irq_req_r;
                rdata_s[IDW+1]   = irq_active_r;
            end
            default:   rdata_s = '0;
        endcase
    end

    assign irq_req    = irq_req_r;
    assign irq_id     = irq_id_r;
    assign irq_active = irq_active_r;
    assign cfg_rdata  = rdata_s;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus randomized bench for irq_ctrl. A behavioural
// model, stepped once per clock, pushes the expected outputs into a queue;
// a monitor pops and compares them on the falling edge.
module tb_irq_ctrl;
    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int W   = 32;

    logic           clk = 1'b0;
    logic           a_reset_n;
    logic [N-1:0]   irq_ext;
    logic           irq_gie;
    logic           irq_req;
    logic [IDW-1:0] irq_id;
    logic           irq_ack;
    logic           irq_done;
    logic           irq_active;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [W-1:0]   cfg_wdata;
    logic [W-1:0]   cfg_rdata;

    int vectors    = 0;
    int miscompares = 0;
    int lat;

    irq_ctrl #(.N_IRQ(N), .W(W)) dut (
        .clk(clk), .a_reset_n(a_reset_n), .irq_ext(irq_ext), .irq_gie(irq_gie),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done),
        .irq_active(irq_active), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Line samples: seen0 is the newest synchronised sample, seen2 the oldest.
    bit [N-1:0] seen0, seen1, seen2;
    bit [N-1:0] latched;      // latched edge events
    bit [N-1:0] m_en, m_mode;
    bit         requesting, servicing;
    int         m_id;

    typedef struct {
        logic           req;
        logic [IDW-1:0] id;
        logic           act;
        logic [W-1:0]   rdata;
    } exp_t;
    exp_t exp_q[$];

    function automatic int first_set(bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [N-1:0] visible_pending();
        bit [N-1:0] p;
        for (int c = 0; c < N; c++) p[c] = m_mode[c] ? latched[c] : seen1[c];
        return p;
    endfunction

    function automatic logic [W-1:0] model_read(logic [1:0] a);
        logic [W-1:0] r;
        r = '0;
        case (a)
            2'd0: r[N-1:0] = m_en;
            2'd1: r[N-1:0] = m_mode;
            2'd2: r[N-1:0] = visible_pending();
            default: r = 32'((servicing ? 16 : 0) + (requesting ? 8 : 0) + m_id);
        endcase
        return r;
    endfunction

    task automatic model_reset();
        seen0 = '0; seen1 = '0; seen2 = '0; latched = '0;
        m_en = '0; m_mode = '1;
        requesting = 1'b0; servicing = 1'b0; m_id = 0;
    endtask

    // One clock edge of the spec's behaviour, using the inputs as driven.
    task automatic model_step();
        bit [N-1:0] elig;
        int win;
        int acked;
        acked = -1;
        elig  = visible_pending() & m_en;
        win   = first_set(elig);
        if (servicing) begin
            if (irq_done) servicing = 1'b0;
        end else if (requesting) begin
            if (irq_ack) begin
                requesting = 1'b0; servicing = 1'b1; acked = m_id;
            end else if (!irq_gie || !elig[m_id]) begin
                requesting = 1'b0;
            end
        end else if (irq_gie && win >= 0) begin
            requesting = 1'b1; m_id = win;
        end
        for (int c = 0; c < N; c++) begin
            bit rise, clr;
            rise = m_mode[c] && seen1[c] && !seen2[c];
            clr  = (cfg_we && cfg_addr == 2'd2 && cfg_wdata[c] && m_mode[c]) || (c == acked);
            if (rise) latched[c] = 1'b1;
            else if (clr) latched[c] = 1'b0;
        end
        if (cfg_we && cfg_addr == 2'd0) m_en   = cfg_wdata[N-1:0];
        if (cfg_we && cfg_addr == 2'd1) m_mode = cfg_wdata[N-1:0];
        seen2 = seen1; seen1 = seen0; seen0 = irq_ext;
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the queued expectation each cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("irq_req",    {31'd0, irq_req},    {31'd0, e.req});
            check("irq_id",     {29'd0, irq_id},     {29'd0, e.id});
            check("irq_active", {31'd0, irq_active}, {31'd0, e.act});
            check("cfg_rdata",  cfg_rdata,           e.rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_step();
        e.req   = requesting;
        e.id    = IDW'(m_id);
        e.act   = servicing;
        e.rdata = model_read(cfg_addr);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic wr(logic [1:0] a, logic [W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycle();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; cycle(); irq_done = 1'b0;
    endtask

    task automatic wait_model_req(int max);
        int n;
        n = 0;
        while (!requesting && n < max) begin cycle(); n++; end
        if (!requesting) begin
            vectors++; miscompares++;
            $display("FAIL wait_req: no request within %0d cycles", max);
        end
    endtask

    task automatic count_to_req(int max);
        lat = 0;
        while (irq_req !== 1'b1 && lat < max) begin cycle(); lat++; end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        a_reset_n = 1'b0; irq_ext = '0; irq_gie = 1'b1; irq_ack = 1'b0;
        irq_done = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        model_reset();
        #12;
        check("rst_req",    {31'd0, irq_req},    32'd0);
        check("rst_id",     {29'd0, irq_id},     32'd0);
        check("rst_active", {31'd0, irq_active}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            check("rst_rdata", cfg_rdata, model_read(2'(a)));
        end
        cfg_addr = 2'd1; #1;
        check("rst_mode", cfg_rdata, 32'h0000_00FF);
        @(negedge clk); #1;
        a_reset_n = 1'b1;

        // Edge channel 0: three-cycle latency, ack clears pending.
        wr(2'd0, 32'h01);
        cfg_addr = 2'd2;
        irq_ext[0] = 1'b1; cycle(); irq_ext[0] = 1'b0;
        count_to_req(10);
        check("edge_latency", 32'(lat), 32'd3);
        check("edge_id", {29'd0, irq_id}, 32'd0);
        pulse_ack();
        check("pend_after_ack", cfg_rdata, 32'h00);
        idle(2); pulse_done(); idle(3);

        // Priority: channels 5 and 2 together, 2 first then 5.
        wr(2'd0, 32'hFF);
        irq_ext = 8'h24; cycle(); irq_ext = '0;
        wait_model_req(10);
        check("prio_first", {29'd0, irq_id}, 32'd2);
        pulse_ack(); idle(2); pulse_done();
        count_to_req(10);
        check("prio_gap", 32'(lat), 32'd1);
        check("prio_second", {29'd0, irq_id}, 32'd5);
        pulse_ack(); idle(1); pulse_done(); idle(3);

        // Level channel 3: 2-cycle latency, re-request, withdrawal.
        wr(2'd1, 32'hF7);
        wr(2'd0, 32'h08);
        irq_ext[3] = 1'b1; cycle();
        count_to_req(10);
        check("level_latency", 32'(lat), 32'd2);
        pulse_ack(); idle(1); pulse_done();
        wait_model_req(5);
        irq_ext[3] = 1'b0;
        idle(5);
        check("level_withdraw", {31'd0, irq_req}, 32'd0);
        wr(2'd1, 32'hFF);

        // Global enable off holds a pending edge; re-enabling requests in 1 cycle.
        wr(2'd0, 32'h01);
        irq_gie = 1'b0; cfg_addr = 2'd2;
        irq_ext[0] = 1'b1; cycle(); irq_ext[0] = 1'b0;
        idle(6);
        check("gie_hold_pend", cfg_rdata, 32'h01);
        irq_gie = 1'b1; cycle();
        check("gie_req", {31'd0, irq_req}, 32'd1);
        pulse_ack(); pulse_done(); idle(2);

        // Edge set coincident with W1C on channel 1 (channel disabled).
        wr(2'd0, 32'h00);
        irq_ext = 8'h02; cycle(); irq_ext = '0; cycle();
        irq_ext = 8'h02; cycle(); irq_ext = '0; cycle();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h02; cycle();
        cfg_we = 1'b0; cfg_wdata = '0;
        check("w1c_vs_set", cfg_rdata, 32'h02);
        wr(2'd2, 32'h02);
        check("w1c_clear", cfg_rdata, 32'h00);

        // Ack of channel 1 coincident with a new edge on channel 1.
        wr(2'd0, 32'h02);
        cfg_addr = 2'd2;
        irq_ext = 8'h02; cycle(); irq_ext = '0; cycle();
        irq_ext = 8'h02; cycle(); irq_ext = '0; cycle();
        pulse_ack();
        check("ack_vs_set", cfg_rdata, 32'h02);
        idle(1); pulse_done();
        wait_model_req(5);
        check("reserve_id", {29'd0, irq_id}, 32'd1);
        pulse_ack(); pulse_done(); idle(2);

        // Asynchronous reset while servicing.
        wr(2'd0, 32'h01);
        irq_ext[0] = 1'b1; cycle(); irq_ext[0] = 1'b0;
        wait_model_req(10);
        pulse_ack();
        a_reset_n = 1'b0; #1;
        check("arst_active", {31'd0, irq_active}, 32'd0);
        check("arst_req",    {31'd0, irq_req},    32'd0);
        cfg_addr = 2'd3; #1;
        check("arst_status", cfg_rdata, 32'd0);
        cfg_addr = 2'd0; #1;
        check("arst_enable", cfg_rdata, 32'd0);
        model_reset();
        @(negedge clk); #1;
        a_reset_n = 1'b1;
        idle(2);

        // Randomized traffic against the model.
        wr(2'd0, 32'hFF);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) irq_ext = irq_ext ^ N'(1 << $urandom_range(0, N - 1));
            irq_gie   = ($urandom_range(0, 9) != 0);
            irq_ack   = ($urandom_range(0, 2) == 0);
            irq_done  = ($urandom_range(0, 3) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_we    = ($urandom_range(0, 11) == 0);
            cfg_wdata = $urandom();
            if (cfg_we && cfg_addr == 2'd0) cfg_wdata[N-1:0] = cfg_wdata[N-1:0] | 8'hC3;
            cycle();
        end
        irq_ext = '0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0; irq_gie = 1'b1;
        idle(4);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
